// File: rtl/scr_pkg.sv
// rtl/scr_pkg.sv - shared keystream constants, FSM state type and bits-per-byte for the scrambler pair
// Optional parity bit per byte is selected by SCRAMBLER_TX_PARITY_EN.
package scr_pkg;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] SEED = 15'b101011111100101;
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;
  localparam int DATA_W_DEF = 8;

`ifdef SCRAMBLER_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int BITS_PER_BYTE = DATA_W_DEF + PARITY_BITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scr_state_e;

endpackage

// File: rtl/lfsr_keystream.sv
// rtl/lfsr_keystream.sv - free-running Fibonacci LFSR keystream shared by scrambler and descrambler
// Advances on every clock out of reset; bit 0 is the keystream bit for the current cycle.
module lfsr_keystream #(
  parameter int                LFSR_W = scr_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED   = scr_pkg::SEED,
  parameter int                TAP_HI = scr_pkg::TAP_HI,
  parameter int                TAP_LO = scr_pkg::TAP_LO
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state,
  output logic              ks_bit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= {state[LFSR_W-2:0], state[TAP_HI] ^ state[TAP_LO]};
    end
  end

  assign ks_bit = state[0];

endmodule

// File: rtl/scrambler_tx.sv
// rtl/scrambler_tx.sv - byte-in, serial-out additive scrambler, LSB first, one bit per clock
// Defining SCRAMBLER_TX_PARITY_EN appends an even-parity bit after each byte's MSB.
module scrambler_tx #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = scr_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED   = scr_pkg::SEED,
  parameter int                TAP_HI = scr_pkg::TAP_HI,
  parameter int                TAP_LO = scr_pkg::TAP_LO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              scrambled_out,
  output logic              out_valid,
  output logic              out_last,
  output logic [LFSR_W-1:0] lfsr_state
);

  import scr_pkg::*;

  localparam int NBITS = DATA_W + PARITY_BITS;
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  scr_state_e       state, state_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_q, last_nxt;
  logic [NBITS-1:0] load_word;
  logic             ks_bit;
  logic             final_bit;
  logic             accept;
  logic             cur_bit;

  lfsr_keystream #(
    .LFSR_W(LFSR_W),
    .SEED  (SEED),
    .TAP_HI(TAP_HI),
    .TAP_LO(TAP_LO)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state),
    .ks_bit(ks_bit)
  );

`ifdef SCRAMBLER_TX_PARITY_EN
  assign load_word = {^in_data, in_data};
`else
  assign load_word = in_data;
`endif

  // The final bit cycle doubles as the load slot so back-to-back bytes have no bubble.
  assign final_bit     = (state == SHIFT) && (cnt == CNT_W'(NBITS - 1));
  assign in_ready      = (state == IDLE) || final_bit;
  assign accept        = in_valid && in_ready;
  assign out_valid     = (state == SHIFT);
  assign out_last      = final_bit && last_q;
  assign cur_bit       = (state == SHIFT) && shreg[0];
  assign scrambled_out = cur_bit ^ (ks_bit & enable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      last_q <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = load_word;
          cnt_nxt   = '0;
          last_nxt  = in_last;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_nxt = load_word;
          cnt_nxt   = '0;
          last_nxt  = in_last;
        end else if (final_bit) begin
          state_nxt = IDLE;
          shreg_nxt = '0;
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
        end else begin
          shreg_nxt = shreg >> 1;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scrambler_tx.sv
// tb/tb_scrambler_tx.sv - self-checking bench for scrambler_tx against a bit-sequence keystream model
// Honours SCRAMBLER_TX_PARITY_EN when defined for both bench and design.
module tb_scrambler_tx;

  localparam logic [14:0] SEED = 15'b101011111100101;
`ifdef SCRAMBLER_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int KS_N = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready, scrambled_out, out_valid, out_last;
  logic [14:0] lfsr_state;

  int n_checks = 0;
  int n_pass = 0;

  scrambler_tx dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .scrambled_out(scrambled_out),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .lfsr_state   (lfsr_state)
  );

  always #5 clk = ~clk;

  // Keystream as a plain bit sequence: b(n) = b(n-15) ^ b(n-14), b(-i) = SEED[i].
  bit ks_seq [KS_N + 15];

  typedef struct {
    bit b;
    bit last;
  } pbit_t;

  pbit_t pend[$];
  int    t = 0;
  bit    chk_on = 1'b0;

  function automatic bit ks(int n);
    return ks_seq[n + 14];
  endfunction

  function automatic logic [14:0] exp_state();
    logic [14:0] s;
    for (int i = 0; i < 15; i++) s[i] = ks(t - i);
    return s;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of pending line bits; head is the bit on the line this cycle.
  bit    m_acc;
  pbit_t m_e;
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      pend.delete();
    end else begin
      m_acc = in_valid && (pend.size() <= 1);
      if (pend.size() > 0) void'(pend.pop_front());
      if (m_acc) begin
        for (int i = 0; i < NB; i++) begin
          m_e.b    = (i < 8) ? in_data[i] : ^in_data;
          m_e.last = in_last && (i == NB - 1);
          pend.push_back(m_e);
        end
      end
      t++;
    end
  end

  bit e_v, e_b, e_l;
  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_out_last", 32'(out_last), 32'(1'b0));
        check("rst_in_ready", 32'(in_ready), 32'(1'b1));
        check("rst_lfsr", 32'(lfsr_state), 32'(SEED));
      end else begin
        e_v = pend.size() > 0;
        e_b = e_v ? pend[0].b : 1'b0;
        e_l = e_v && pend[0].last;
        check("out_valid", 32'(out_valid), 32'(e_v));
        check("in_ready", 32'(in_ready), 32'(pend.size() <= 1));
        check("out_last", 32'(out_last), 32'(e_l));
        check("lfsr_state", 32'(lfsr_state), 32'(exp_state()));
        check("descrambled", 32'(scrambled_out ^ (ks(t) & enable)), 32'(e_b));
      end
    end
  end

  logic [15:0] v_rec, b_rec, r_rec;
  int last_cnt, last_pos, sent, cyc;
  bit holding;

  initial begin
    for (int i = 0; i < 15; i++) ks_seq[14 - i] = SEED[i];
    for (int n = 1; n < KS_N; n++) ks_seq[n + 14] = ks_seq[n - 1] ^ ks_seq[n];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Idle after reset: keystream alone on the line.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_bit", 32'(scrambled_out), 32'(1'b1));
      check("idle_valid", 32'(out_valid), 32'(1'b0));
      if (i == 0) check("seed", 32'(lfsr_state), 32'h57E5);
      if (i == 1) check("lfsr_step1", 32'(lfsr_state), 32'h2FCB);
      @(posedge clk); #1;
    end

    v_rec = '0; b_rec = '0; r_rec = '0;
    enable = 1'b0;
`ifndef SCRAMBLER_TX_PARITY_EN
    in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v_rec[i] = out_valid; b_rec[i] = scrambled_out; r_rec[i] = in_ready;
      @(posedge clk); #1;
      if (i == 7) in_valid = 1'b0;
    end
    check("ab_valid", 32'(v_rec), 32'hFFFF);
    check("ab_bits", 32'(b_rec), 32'h3CA5);
    check("ab_ready", 32'(r_rec), 32'h8080);
`else
    in_valid = 1'b1; in_data = 8'h07; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      v_rec[i] = out_valid; b_rec[i] = scrambled_out; r_rec[i] = in_ready;
      @(posedge clk); #1;
    end
    check("par_valid", 32'(v_rec), 32'h01FF);
    check("par_bits", 32'(b_rec), 32'h0107);
    check("par_ready", 32'(r_rec), 32'h0100);
`endif
    @(posedge clk); #1;

    // Two-byte frame: out_last only on the final bit of the second byte.
    enable = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h22; in_last = 1'b1;
    last_cnt = 0; last_pos = -1;
    for (int i = 0; i < 2 * NB + 3; i++) begin
      @(negedge clk);
      if (out_last) begin last_cnt++; last_pos = i; end
      @(posedge clk); #1;
      if (i == NB - 1) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    check("last_count", 32'(last_cnt), 32'd1);
    check("last_pos", 32'(last_pos), 32'(2 * NB - 1));

    // Reset during bit 3 of 0xFF.
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'(1'b0));
    check("midrst_ready", 32'(in_ready), 32'(1'b1));
    check("midrst_lfsr", 32'(lfsr_state), 32'h57E5);
    check("midrst_bit", 32'(scrambled_out), 32'(1'b1));
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    check("post_rst_seed", 32'(lfsr_state), 32'h57E5);
    check("post_rst_idle", 32'(out_valid), 32'(1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_bit0_valid", 32'(out_valid), 32'(1'b1));
    check("post_rst_bit0", 32'(scrambled_out), 32'(1'b1));
    repeat (NB + 2) @(posedge clk);
    #1;

    // Random bytes, gaps, frame ends and enable toggling.
    sent = 0; cyc = 0; holding = 1'b0;
    while (sent < 256 && cyc < 15000) begin
      enable = ($urandom_range(0, 7) != 0);
      if (!holding) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = 8'($urandom);
          in_last  = 1'($urandom_range(0, 1));
          holding  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (in_valid && pend.size() <= 1) begin
        sent++;
        holding = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("random_sent", 32'(sent), 32'd256);
    repeat (NB + 2) @(posedge clk);
    #1;

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scrambler_tx.md
Name: scrambler_tx

Overview:
- Transmit-side additive scrambler matching the team's 15-bit LFSR serial descrambler (x^15 + x^14 + 1, seed 15'b101011111100101).
- Accepts bytes over a valid/ready interface and serializes them LSB-first, one bit per clock.
- XORs each bit with the free-running LFSR keystream.
- Sits between the framing logic and the serial line driver; TX and RX share clk/rst so their keystreams stay in lockstep.

Parameters:
- DATA_W, 8, input word width in bits.
- LFSR_W, 15, keystream register width.
- SEED, 15'b101011111100101, LFSR reset value.
- TAP_HI, 14, first feedback tap index.
- TAP_LO, 13, second feedback tap index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  scrambling enable; 0 = bits pass through unscrambled.
- in_data  in  DATA_W  byte to transmit.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  final byte of frame.
- in_ready  out  1  block accepts in_data this cycle.
- scrambled_out  out  1  serial line bit.
- out_valid  out  1  current bit carries payload (0 = idle fill).
- out_last  out  1  current bit is the final bit of the in_last byte.
- lfsr_state  out  LFSR_W  current keystream register (debug/verification).

Behaviour:
- Clocking and reset: clk is the clock; rst is asynchronous, active-high.
- Reset values:
  - lfsr_state = SEED.
  - FSM = IDLE, shift register = 0, bit counter = 0.
  - out_valid = 0, out_last = 0, in_ready = 1.
- LFSR:
  - Advances every clock after reset, regardless of enable, FSM state or handshake.
  - lfsr[0] <= lfsr[TAP_HI] ^ lfsr[TAP_LO]; lfsr[i] <= lfsr[i-1] for i = 1..14.
- Output: scrambled_out = cur_bit ^ (lfsr[0] & enable), combinational from registered cur_bit, lfsr[0] and enable.
  - cur_bit = shift register LSB in SHIFT, 0 in IDLE.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid & in_ready, load in_data and in_last, clear counter, go to SHIFT.
  - SHIFT: out_valid = 1. Each clock shift right and increment counter. The bit count per byte is DATA_W (DATA_W+1 with parity).
  - On the final bit cycle, in_ready = 1. If a byte is accepted, reload and stay in SHIFT (zero-bubble back-to-back). Otherwise go to IDLE.
- Latency: byte accepted at edge k; its bit 0 appears in the cycle following edge k.
- out_last is high only on the final bit of a byte loaded with in_last = 1.
- in_ready is low on non-final SHIFT cycles; in_valid may be held.
- enable may change on any cycle; it applies per bit and never disturbs the LFSR.
- Reset mid-byte: the byte is dropped, the FSM returns to IDLE, and the LFSR is reseeded immediately (async).

Optional Feature:
- Macro SCRAMBLER_TX_PARITY_EN.
- Defined:
  - One extra bit (even parity = XOR of the DATA_W data bits) is sent after each byte's MSB, scrambled like data.
  - That parity bit is the final bit; in_ready and out_last move to it.
- Undefined: DATA_W bits per byte, no parity logic synthesized.

Decomposition:
- Package scr_pkg holds:
  - LFSR_W, SEED, TAP_HI, TAP_LO constants.
  - FSM state enum (IDLE, SHIFT).
  - Bits-per-byte constant selected by the parity macro.
- One sub-module, lfsr_keystream: free-running LFSR exposing state and lfsr[0]. It is reusable by the descrambler.

Test Plan:
- Reset, enable = 1, in_valid = 0 for 4 cycles -> scrambled_out = 1,1,1,1, out_valid = 0, lfsr_state = SEED in cycle 0.
- enable = 0, send 0xA5 then 0x3C with in_valid held:
  - 16 consecutive out_valid cycles.
  - scrambled_out = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - in_ready high only in cycles 7 and 15.
- enable = 1, loop back to the descrambler on the same clk/rst, 256 random bytes with random in_valid gaps -> descrambled_out equals the transmitted bit sequence on every out_valid cycle.
- Assert rst during bit 3 of 0xFF -> outputs return to reset values at once. The next byte starts at bit 0 with lfsr_state = SEED after release.
- Frame 0x11, 0x22 (in_last on 0x22) -> out_last high for exactly one cycle, on bit 7 of 0x22.
- With SCRAMBLER_TX_PARITY_EN defined, enable = 0, send 0x07:
  - 9 bits 1,1,1,0,0,0,0,0,1 (parity 1).
  - in_ready high on the 9th bit.
